// File: rtl/ofifo.sv
// rtl/ofifo.sv - output alignment FIFO: one lane FIFO per array column, popped as one aligned vector
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr_i,
  input  logic [col*psum_bw-1:0]   in_i,
  input  logic                     rd_i,
  output logic [col*psum_bw-1:0]   out_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     ready_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one  = (aw+1)'(1);
  localparam logic [aw:0] cnt_full = (aw+1)'(depth);

  // Lanes only ever pop together, so one shared read pointer serves all of them.
  logic [aw:0]        wptr [col];
  logic [aw:0]        rptr;
  logic [psum_bw-1:0] mem  [col][depth];

  logic [col-1:0] lane_full;
  logic [col-1:0] lane_empty;
  logic [col-1:0] wr_ok;
  logic           rd_ok;

  always_comb begin
    lane_full  = '0;
    lane_empty = '0;
    for (int k = 0; k < col; k++) begin
      lane_full[k]  = (wptr[k] - rptr) == cnt_full;
      lane_empty[k] = (wptr[k] == rptr);
    end
  end

  assign valid_o = ~|lane_empty;
  assign full_o  = |lane_full;
  assign ready_o = ~full_o;
  // Fullness is judged before this edge's pop: no write pass-through at full.
  assign wr_ok   = wr_i & ~lane_full;
  assign rd_ok   = rd_i & valid_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < col; k++) wptr[k] <= '0;
      rptr        <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      for (int k = 0; k < col; k++) begin
        if (wr_ok[k]) wptr[k] <= wptr[k] + ptr_one;
      end
      if (rd_ok) rptr <= rptr + ptr_one;
      if (|(wr_i & lane_full)) overflow_o  <= 1'b1;
      if (rd_i && !valid_o)    underflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < col; k++) begin
      if (wr_ok[k]) mem[k][wptr[k][aw-1:0]] <= in_i[k*psum_bw +: psum_bw];
    end
  end

  for (genvar g = 0; g < col; g++) begin : g_lane_out
    assign out_o[g*psum_bw +: psum_bw] = mem[g][rptr[aw-1:0]];
  end

endmodule

// File: tb/tb_ofifo.sv
// tb/tb_ofifo.sv - directed and random checks of ofifo against a queue-per-lane reference model
module tb_ofifo;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [COL-1:0]      wr_i;
  logic [COL*BW-1:0]   in_i;
  logic                rd_i;
  logic [COL*BW-1:0]   out_o;
  logic                valid_o, full_o, ready_o, overflow_o, underflow_o;

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_i(wr_i), .in_i(in_i), .rd_i(rd_i),
    .out_o(out_o), .valid_o(valid_o), .full_o(full_o), .ready_o(ready_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] mq [COL][$];
  bit m_ovf, m_unf;
  int errors = 0;
  int checks = 0;

  function automatic bit m_valid();
    for (int k = 0; k < COL; k++) if (mq[k].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int k = 0; k < COL; k++) if (mq[k].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [COL*BW-1:0] rep(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  task automatic chk(input string tag, input logic [COL*BW-1:0] obs, input logic [COL*BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [COL*BW-1:0] exp;
    chk({tag, ".valid"},     valid_o,     m_valid());
    chk({tag, ".full"},      full_o,      m_full());
    chk({tag, ".ready"},     ready_o,     !m_full());
    chk({tag, ".overflow"},  overflow_o,  m_ovf);
    chk({tag, ".underflow"}, underflow_o, m_unf);
    if (m_valid()) begin
      for (int k = 0; k < COL; k++) exp[k*BW +: BW] = mq[k][0];
      chk({tag, ".out"}, out_o, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < COL; k++) mq[k].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_edge(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    bit v;
    v = m_valid();
    for (int k = 0; k < COL; k++) begin
      if (w[k]) begin
        if (mq[k].size() == DEPTH) m_ovf = 1'b1;
        else mq[k].push_back(d[k*BW +: BW]);
      end
    end
    if (r) begin
      if (v) for (int k = 0; k < COL; k++) void'(mq[k].pop_front());
      else m_unf = 1'b1;
    end
  endtask

  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    wr_i = w;
    in_i = d;
    rd_i = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    wr_i = '0;
    rd_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [COL*BW-1:0] d;
    reset = 1'b0;
    wr_i  = '0;
    in_i  = '0;
    rd_i  = 1'b0;
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // read on an empty FIFO, then a normal write/read pair
    step('0, '0, 1'b1);             check_all("empty_rd");
    step(8'hFF, rep(16'h0055), 1'b0); check_all("after_empty_wr");
    step('0, '0, 1'b1);             check_all("after_empty_rd");

    // skewed fill: valid only after the last lane is written
    do_reset("rst_skew");
    for (int k = 0; k < COL; k++) begin
      d = '0;
      d[k*BW +: BW] = 16'h0100 + 16'(k);
      step(COL'(1) << k, d, 1'b0);
      check_all($sformatf("skew%0d", k));
    end

    // fill lane 0 past full, then line it up with the other lanes and drain
    do_reset("rst_fill0");
    for (int i = 0; i < 5; i++) begin
      step(8'h01, rep(16'h0011 + 16'(i)), 1'b0);
      check_all($sformatf("fill0_w%0d", i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(8'hFE, rep(16'h0200 + 16'(i)), 1'b0);
      check_all($sformatf("fill0_others%0d", i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      step('0, '0, 1'b1);
      check_all($sformatf("fill0_pop%0d", i));
    end

    // wrap-around stream
    do_reset("rst_wrap");
    for (int i = 0; i < 20; i++) begin
      step(8'hFF, rep(16'(i)), 1'b0); check_all($sformatf("wrap_w%0d", i));
      step('0, '0, 1'b1);             check_all($sformatf("wrap_r%0d", i));
    end

    // concurrent push and pop while full
    do_reset("rst_conc");
    for (int i = 0; i < DEPTH; i++) begin
      step(8'hFF, rep(16'h0300 + 16'(i)), 1'b0);
      check_all($sformatf("conc_fill%0d", i));
    end
    step(8'hFF, rep(16'h00AA), 1'b1);
    check_all("conc_pushpop");
    for (int i = 0; i < DEPTH - 1; i++) begin
      step('0, '0, 1'b1);
      check_all($sformatf("conc_drain%0d", i));
    end

    // reset in the middle of buffered data
    do_reset("rst_mid_pre");
    step('0, '0, 1'b1); check_all("mid_unf");
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, rep(16'h0400 + 16'(i)), 1'b0);
      check_all($sformatf("mid_w%0d", i));
    end
    do_reset("rst_mid");
    step(8'hFF, rep(16'h0BEE), 1'b0);
    check_all("mid_after");

    // random traffic
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < COL; k++) d[k*BW +: BW] = 16'($urandom);
      step(COL'($urandom), d, 1'($urandom_range(0, 1)));
      check_all($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output alignment FIFO between the systolic array and the special-function stage. Each of the `col` array columns produces psums at a different cycle because of systolic skew.
- The block buffers each column in its own lane FIFO and presents a full, column-aligned psum vector only when every lane has data.
- Its output vector feeds the special-function unit's `psum_in`. The read strobe is driven by the controller.

Parameters:
- `col`, 8, number of lanes (array columns).
- `psum_bw`, 16, psum width per lane in bits.
- `depth`, 64, entries per lane; must be a power of two and at least 2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `wr_i`  input  col  per-lane write strobe; bit k pushes lane k.
- `in_i`  input  col*psum_bw  per-lane write data; lane k occupies bits [(k+1)*psum_bw-1 : k*psum_bw].
- `rd_i`  input  1  pops one entry from every lane at once.
- `out_o`  output  col*psum_bw  head entry of each lane, same lane packing as `in_i`.
- `valid_o`  output  1  all lanes non-empty.
- `full_o`  output  1  at least one lane holds `depth` entries.
- `ready_o`  output  1  equal to NOT `full_o`.
- `overflow_o`  output  1  sticky; a write was dropped.
- `underflow_o`  output  1  sticky; a read was ignored.

Behaviour:
- Storage:
  - Each lane is a circular buffer of `depth` x `psum_bw` bits.
  - Write and read pointers are log2(`depth`)+1 bits wide; the extra MSB distinguishes full from empty.
  - Lane count = wptr - rptr. Lane empty: count = 0. Lane full: count = `depth`.
- Write acceptance:
  - Lane k accepts `wr_i[k]` only if lane k is not full, judged on the state at the start of the cycle.
  - A write into a full lane is dropped even if `rd_i` pops that lane in the same cycle (no pass-through).
  - A dropped write sets `overflow_o`; the lane contents are unchanged.
- Read acceptance:
  - `rd_i` is accepted only if `valid_o` = 1; all lanes then advance `rptr` together.
  - `rd_i` while `valid_o` = 0 changes nothing and sets `underflow_o`.
- Simultaneous read and write on a lane that is neither full nor empty: both take effect, and the count is unchanged.
- Output timing:
  - `out_o` is first-word-fall-through: the combinational read of each lane's entry at `rptr`.
  - A word written at edge N is visible on `out_o` after edge N, provided it is the lane head.
  - `valid_o`, `full_o` and `ready_o` are combinational from the pointers. `valid_o` rises in the cycle after the edge that fills the last empty lane.
  - While `valid_o` = 0, `out_o` is don't-care. The bench compares `out_o` only while `valid_o` = 1.
- Pointer wrap-around: index bits wrap modulo `depth`; the MSB toggles on each wrap.
- Lanes are independent: a full or empty lane never blocks writes to other lanes.
- Reset:
  - Asynchronous assertion (`reset` = 0) clears all pointers, `overflow_o` and `underflow_o`.
  - Outputs during and after reset: `valid_o` = 0, `full_o` = 0, `ready_o` = 1.
  - Storage contents are not reset.
  - Reset asserted mid-burst discards all buffered data; the first write after deassertion lands at index 0.
- Sticky flags clear only on reset.
- Arithmetic: data is passed bit-exact, with no sign handling or modification.

Test Plan (`col`=8, `psum_bw`=16, `depth`=4 unless stated):
- Skewed fill: lane k writes value 16'h0100+k at cycle k (k=0..7), with `rd_i`=0 -> `valid_o` stays 0 through the lane-7 write edge and rises the cycle after. `out_o` lane k = 16'h0100+k. `full_o`=0.
- Fill lane 0: write 16'h0011, 0012, 0013, 0014 -> `full_o`=1 and `ready_o`=0 after the 4th edge. A 5th write (16'h0015) is dropped and `overflow_o`=1. Lane 0 still pops 0011..0014 in order once the other lanes are filled.
- Empty read: after reset, `rd_i`=1 for one cycle -> pointers unchanged, `underflow_o`=1, `valid_o`=0. A subsequent valid write/read sequence works normally.
- Wrap-around stream: 20 full-vector writes, each followed one cycle later by a read, with values 0..19 in every lane -> `out_o` reads 0..19 in order, with no overflow or underflow.
- Concurrent push/pop at full: all lanes full, then `rd_i`=1 and `wr_i`=8'hFF with data 16'h00AA in the same cycle -> the oldest entry is popped, the writes are dropped, `overflow_o`=1, and the count becomes 3.
- Reset mid-operation: 3 entries per lane, then pull `reset` low between edges -> `valid_o`=0 immediately and flags clear. After release, a write of 16'h0BEE to all lanes gives `out_o`=16'h0BEE in every lane.
